uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Configurable UART receiver and the successor to the basic 8N1 receiver. It adds:
- runtime-selectable data length (5..MAX_DATA_WIDTH), none/even/odd parity, and 1 or 2 stop bits;
- 16x oversampling with 3-sample majority voting and an input synchroniser;
- per-character framing, parity and break status stored in the RX FIFO, plus a sticky overrun flag.

It sits between the pad-side serial line and the register/bus interface of the UART peripheral.

Parameters:
MAX_DATA_WIDTH, 8, widest supported character; legal range 5..9.
FIFO_DEPTH, 16, RX FIFO entries; power of two, >=2.
SYNC_STAGES, 2, flip-flop stages on rx_bit_i; >=2.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
baud_div_i  in  16  oversample tick divider; tick period = baud_div_i+1 clocks; bit = 16 ticks
rx_en_i  in  1  receiver enable
data_bits_i  in  4  character length; values <5 act as 5, values >MAX_DATA_WIDTH act as MAX_DATA_WIDTH
parity_en_i  in  1  parity bit present
parity_odd_i  in  1  1 = odd parity, 0 = even parity
stop2_i  in  1  1 = two stop bits
rx_bit_i  in  1  asynchronous serial input, idle high
rx_re_i  in  1  pop FIFO head
clr_overrun_i  in  1  clear sticky overrun
dout_o  out  MAX_DATA_WIDTH  FIFO head data, LSB = first received bit, unused upper bits 0
frame_err_o  out  1  FIFO head: stop-bit error
parity_err_o  out  1  FIFO head: parity mismatch
break_o  out  1  FIFO head: break character
overrun_o  out  1  sticky: character dropped because FIFO was full
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
Clock and reset:
- Reset and clock are rst_ni (asynchronous, active-low) and clk_i.
- Reset values: synchroniser flops 1; state IDLE; counters 0; FIFO empty.
- Output reset values: empty_o=1, full_o=0, level_o=0, overrun_o=0; dout_o and the status outputs read 0.

Sampling:
- rx_bit_i passes through SYNC_STAGES flops; rx_s denotes the synchroniser output.
- The prescaler counts 0..baud_div_i and pulses tick when equal, then wraps. baud_div_i=0 gives a tick every clock.
- The prescaler is held at 0 in IDLE.
- A 4-bit sample counter advances per tick. Samples are captured at counts 7, 8 and 9.
- The bit value is the 2-of-3 majority, decided at count 9. The bit period ends at count 15.

Arming:
- IDLE accepts a start edge only after rx_s=1 has been seen while rx_en_i=1.
- This prevents a held-low line or break from retriggering reception.

FSM (IDLE, START, DATA, PARITY, STOP1, STOP2):
- IDLE: armed, rx_en_i=1 and rx_s=0 -> START. Prescaler and sample counter clear.
- START, at count 9:
  - majority 1 -> IDLE (false start, nothing written);
  - majority 0 -> latch data_bits_i, parity_en_i, parity_odd_i and stop2_i into a frame config; clear the bit counter.
  - At count 15 -> DATA.
- DATA:
  - each count 9 stores the majority into shift position bit_cnt (LSB first);
  - after the last bit's count 15 -> PARITY if parity is enabled, else STOP1.
- PARITY: at count 9 compute p = XOR(data bits, parity bit).
  - Even: error if p=1. Odd: error if p=0.
  - At count 15 -> STOP1.
- STOP1: at count 9, frame_err is set if the sample is 0.
  - If stop2: go to STOP2 at count 15.
  - Else: write to the FIFO at this count-9 tick and go to IDLE. This allows a half-bit resync margin.
- STOP2: at count 9, frame_err |= (sample == 0). Write to the FIFO and go to IDLE.
- Break: all data bits 0, parity bit 0 (if enabled) and the first stop bit 0. Sets break and frame_err; the arm flag clears.
- Config changes mid-frame are ignored; the latched frame config applies to the whole frame.
- rx_en_i=0 in any state -> IDLE next cycle. A partial frame is discarded, no write, FIFO untouched.

FIFO:
- Entry = {break, parity_err, frame_err, data}.
- First-word-fall-through: the head is valid on the outputs whenever empty_o=0.
- Write latency: entry visible on outputs the cycle after the write tick.
- rx_re_i with empty FIFO is ignored.
- Write with full_o=1 and no same-cycle read: the entry is dropped and overrun_o is set.
- Write and read in the same cycle while full: both succeed, no overrun, level unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Overrun:
- overrun_o stays set until a clr_overrun_i cycle.
- If a set and a clear occur in the same cycle, the set wins.

Receiver independence:
- The receiver never stalls on full; it always tracks the line.

Test Plan:
- 8N1, baud_div_i=0, send 0xA5 -> one FIFO entry 0xA5, all flags 0. Entry visible about 16*9.5 + SYNC_STAGES clocks after the start edge.
- 7E2, baud_div_i=3: send 0x35 with a correct parity bit, then 0x35 with a wrong parity bit -> second entry has parity_err_o=1. Repeat with 7O2 -> parity sense inverted.
- 5-clock glitch low on idle line, baud_div_i=0 -> back to IDLE, empty_o stays 1.
- Send line low for 2 character times, then high -> exactly one entry: data 0, break_o=1, frame_err_o=1. Next real character is received normally.
- Send 17 characters with no reads (FIFO_DEPTH=16) -> full_o=1, level_o=16, overrun_o=1. First 16 bytes are intact. clr_overrun_i clears the flag.
- Drop rx_en_i mid-data, then re-enable and send 0x3C -> only 0x3C is in the FIFO. Also assert rst_ni low mid-frame -> all outputs take their reset values.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable 16x-oversampled UART receiver with a status-tagged RX FIFO.
// The FIFO is first-word-fall-through and is written when the last stop bit is sampled.
module uart_rx_cfg #(
  parameter int MAX_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [15:0]                   baud_div_i,
  input  logic                          rx_en_i,
  input  logic [3:0]                    data_bits_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  input  logic                          rx_bit_i,
  input  logic                          rx_re_i,
  input  logic                          clr_overrun_i,
  output logic [MAX_DATA_WIDTH-1:0]     dout_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          break_o,
  output logic                          overrun_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int W = MAX_DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] MAXB = 4'(MAX_DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;
  state_e state, state_nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic [15:0] presc;
  logic [3:0] scnt, bit_cnt, cfg_bits;
  logic rx_s, tick, maj_tick, end_tick, s0, s1, maj, armed, last;
  logic cfg_par, cfg_odd, cfg_stop2, perr, pbit, ferr;
  logic wr, wr_brk, wr_ferr, do_wr, do_rd;
  logic [W-1:0] shreg;
  logic [W+2:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;

  assign rx_s = sync[SYNC_STAGES-1];
  assign tick = state != IDLE && presc >= baud_div_i;
  assign maj_tick = tick && scnt == 4'd9;
  assign end_tick = tick && scnt == 4'd15;
  assign maj = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign last = bit_cnt == cfg_bits - 4'd1;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (armed && !rx_s) state_nxt = START;
      START:   if (maj_tick && maj) state_nxt = IDLE;
               else if (end_tick) state_nxt = DATA;
      DATA:    if (end_tick && last) state_nxt = cfg_par ? PARITY : STOP1;
      PARITY:  if (end_tick) state_nxt = STOP1;
      STOP1:   if (maj_tick && !cfg_stop2) state_nxt = IDLE;
               else if (end_tick) state_nxt = STOP2;
      STOP2:   if (maj_tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!rx_en_i) state_nxt = IDLE;
  end

  // In STOP2 the first stop-bit error is already held in ferr; in STOP1 it is the live sample.
  always_comb begin
    wr = rx_en_i && maj_tick && ((state == STOP1 && !cfg_stop2) || state == STOP2);
    wr_ferr = state == STOP2 ? ferr | ~maj : ~maj;
    wr_brk = shreg == '0 && !(cfg_par && pbit) && (state == STOP2 ? ferr : ~maj);
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync <= '1;
      presc <= '0;
      scnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx_bit_i};
      presc <= (state == IDLE || tick) ? '0 : presc + 16'd1;
      scnt <= state == IDLE ? '0 : scnt + 4'(tick);
    end

  // A break leaves the line low, so the arm flag keeps it from being seen as a new start.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      armed <= 1'b0;
      cfg_bits <= 4'd5;
      cfg_par <= 1'b0;
      cfg_odd <= 1'b0;
      cfg_stop2 <= 1'b0;
      bit_cnt <= '0;
      shreg <= '0;
      perr <= 1'b0;
      pbit <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (tick && scnt == 4'd7) s0 <= rx_s;
      if (tick && scnt == 4'd8) s1 <= rx_s;
      armed <= !rx_en_i ? 1'b0 : (wr && wr_brk) ? 1'b0 : rx_s ? 1'b1 : armed;
      if (maj_tick)
        case (state)
          START: if (!maj) begin
            cfg_bits <= data_bits_i < 4'd5 ? 4'd5 : data_bits_i > MAXB ? MAXB : data_bits_i;
            cfg_par <= parity_en_i;
            cfg_odd <= parity_odd_i;
            cfg_stop2 <= stop2_i;
            bit_cnt <= '0;
            shreg <= '0;
            perr <= 1'b0;
            pbit <= 1'b0;
          end
          DATA: shreg <= shreg | (W'(maj) << bit_cnt);
          PARITY: begin
            perr <= ^shreg ^ maj ^ cfg_odd;
            pbit <= maj;
          end
          STOP1: ferr <= ~maj;
          default: ;
        endcase
      if (end_tick && state == DATA) bit_cnt <= bit_cnt + 4'd1;
    end

  assign do_rd = rx_re_i && cnt != '0;
  assign do_wr = wr && (!full_o || do_rd);

  always_ff @(posedge clk_i)
    if (do_wr) mem[wp] <= {wr_brk, perr, wr_ferr, shreg};

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overrun_o <= 1'b0;
    end else begin
      wp <= wp + AW'(do_wr);
      rp <= rp + AW'(do_rd);
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      overrun_o <= (wr && full_o && !do_rd) ? 1'b1 : clr_overrun_i ? 1'b0 : overrun_o;
    end

  assign empty_o = cnt == '0;
  assign full_o = cnt == (AW+1)'(FIFO_DEPTH);
  assign level_o = cnt;
  assign {break_o, parity_err_o, frame_err_o, dout_o} = empty_o ? '0 : mem[rp];
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg; frames are built bit by bit with known expected entries.
module tb_uart_rx_cfg;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic [15:0] baud_div = 16'd0;
  logic rx_en = 1'b1, parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
  logic rx_bit = 1'b1, rx_re = 1'b0, clr_overrun = 1'b0;
  logic [3:0] data_bits = 4'd8;
  logic [7:0] dout;
  logic frame_err, parity_err, brk, overrun, full, empty;
  logic [4:0] level;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_rx_cfg dut (
    .clk_i(clk), .rst_ni(rst_ni), .baud_div_i(baud_div), .rx_en_i(rx_en),
    .data_bits_i(data_bits), .parity_en_i(parity_en), .parity_odd_i(parity_odd),
    .stop2_i(stop2), .rx_bit_i(rx_bit), .rx_re_i(rx_re), .clr_overrun_i(clr_overrun),
    .dout_o(dout), .frame_err_o(frame_err), .parity_err_o(parity_err), .break_o(brk),
    .overrun_o(overrun), .full_o(full), .empty_o(empty), .level_o(level)
  );

  wire [10:0] head = {brk, parity_err, frame_err, dout};
  wire [7:0] stat = {empty, full, level, overrun};

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_bit = v[i];
      cyc(16 * (int'(baud_div) + 1));
    end
  endtask

  task automatic send8(input logic [7:0] d);
    send_bits({6'b0, 1'b1, d, 1'b0}, 10);
  endtask

  task automatic send7(input logic [6:0] d, input logic p);
    send_bits({5'b0, 2'b11, p, d, 1'b0}, 11);
  endtask

  task automatic pop();
    rx_re = 1'b1;
    cyc(1);
    rx_re = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    cyc(3);
    checks++; if (stat !== 8'b1_0_00000_0) begin errors++; $display("FAIL reset_status got %b want %b", stat, 8'b1_0_00000_0); end
    checks++; if (head !== 11'h0) begin errors++; $display("FAIL reset_head got %h want %h", head, 11'h0); end
    rst_ni = 1'b1;
    cyc(5);
  endtask

  task automatic test_8n1();
    send_bits({6'b0, 1'b1, 8'hA5, 1'b0}, 9);
    rx_bit = 1'b1;
    cyc(6);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL 8n1_early got empty=%b want 1", empty); end
    cyc(15);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL 8n1_latency got empty=%b want 0", empty); end
    checks++; if (head !== {3'b000, 8'hA5}) begin errors++; $display("FAIL 8n1_head got %h want %h", head, {3'b000, 8'hA5}); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL 8n1_level got %0d want 1", level); end
    pop();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL 8n1_pop got empty=%b want 1", empty); end
  endtask

  task automatic test_parity();
    baud_div = 16'd3; data_bits = 4'd7; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
    cyc(10);
    send7(7'h35, 1'b0);
    send7(7'h35, 1'b1);
    cyc(64);
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL even_level got %0d want 2", level); end
    checks++; if (head !== {3'b000, 8'h35}) begin errors++; $display("FAIL even_ok got %h want %h", head, {3'b000, 8'h35}); end
    pop();
    checks++; if (head !== {3'b010, 8'h35}) begin errors++; $display("FAIL even_bad got %h want %h", head, {3'b010, 8'h35}); end
    pop();
    parity_odd = 1'b1;
    send7(7'h35, 1'b1);
    send7(7'h35, 1'b0);
    cyc(64);
    checks++; if (head !== {3'b000, 8'h35}) begin errors++; $display("FAIL odd_ok got %h want %h", head, {3'b000, 8'h35}); end
    pop();
    checks++; if (head !== {3'b010, 8'h35}) begin errors++; $display("FAIL odd_bad got %h want %h", head, {3'b010, 8'h35}); end
    pop();
    baud_div = 16'd0; data_bits = 4'd8; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    cyc(10);
  endtask

  task automatic test_glitch();
    rx_bit = 1'b0;
    cyc(5);
    rx_bit = 1'b1;
    cyc(100);
    checks++; if (stat !== 8'b1_0_00000_0) begin errors++; $display("FAIL glitch got %b want %b", stat, 8'b1_0_00000_0); end
  endtask

  task automatic test_break();
    rx_bit = 1'b0;
    cyc(320);
    rx_bit = 1'b1;
    cyc(40);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL break_level got %0d want 1", level); end
    checks++; if (head !== {3'b101, 8'h00}) begin errors++; $display("FAIL break_head got %h want %h", head, {3'b101, 8'h00}); end
    pop();
    send8(8'h5A);
    cyc(20);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL after_break_level got %0d want 1", level); end
    checks++; if (head !== {3'b000, 8'h5A}) begin errors++; $display("FAIL after_break_head got %h want %h", head, {3'b000, 8'h5A}); end
    pop();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 17; i++) send8(8'(i + 1));
    cyc(20);
    checks++; if ({full, level, overrun} !== {1'b1, 5'd16, 1'b1}) begin errors++; $display("FAIL ovr_full got %b want %b", {full, level, overrun}, {1'b1, 5'd16, 1'b1}); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (head !== {3'b000, 8'(i + 1)}) begin errors++; $display("FAIL ovr_entry%0d got %h want %h", i, head, {3'b000, 8'(i + 1)}); end
      pop();
    end
    checks++; if ({empty, overrun} !== 2'b11) begin errors++; $display("FAIL ovr_sticky got %b want 11", {empty, overrun}); end
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_disable();
    send_bits(16'h0000, 4);
    rx_en = 1'b0;
    cyc(20);
    rx_bit = 1'b1;
    cyc(20);
    rx_en = 1'b1;
    cyc(20);
    send8(8'h3C);
    cyc(20);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL disable_level got %0d want 1", level); end
    checks++; if (head !== {3'b000, 8'h3C}) begin errors++; $display("FAIL disable_head got %h want %h", head, {3'b000, 8'h3C}); end
  endtask

  task automatic test_reset_mid_frame();
    send_bits(16'h0000, 3);
    rst_ni = 1'b0;
    cyc(2);
    checks++; if (stat !== 8'b1_0_00000_0) begin errors++; $display("FAIL midrst_status got %b want %b", stat, 8'b1_0_00000_0); end
    checks++; if (head !== 11'h0) begin errors++; $display("FAIL midrst_head got %h want %h", head, 11'h0); end
    rx_bit = 1'b1;
    rst_ni = 1'b1;
    cyc(10);
    send8(8'hC3);
    cyc(20);
    checks++; if ({level, head} !== {5'd1, 3'b000, 8'hC3}) begin errors++; $display("FAIL midrst_recover got %h want %h", {level, head}, {5'd1, 3'b000, 8'hC3}); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_disable();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
